// File: rtl/masku_alu_seq_pkg.sv
// Shared types and helpers for the mask-unit ALU result sequencer.
// The mask unit mirrors the ara_pkg definitions it needs here.
package masku_alu_seq_pkg;

    localparam int unsigned ELEN = 64;

    typedef enum logic [1:0] {
        EW8  = 2'd0,
        EW16 = 2'd1,
        EW32 = 2'd2,
        EW64 = 2'd3
    } vew_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } masku_seq_state_e;

    // Datapath width across all lanes
    function automatic int unsigned masku_dw(int unsigned nr_lanes);
        return nr_lanes * ELEN;
    endfunction

    function automatic int unsigned idx_width(int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // Elements (and mask bits) delivered per beat for a given element width
    function automatic int unsigned beat_elems(vew_e vsew, int unsigned nr_lanes);
        return masku_dw(nr_lanes) >> (32'd3 + 32'(vsew));
    endfunction

endpackage

// File: rtl/masku_alu_seq_if.sv
// Instruction, operand and write-back bundle of the mask result sequencer.
// master drives requests/operands, slave is the sequencer.
interface masku_alu_seq_if #(
    parameter int unsigned NrLanes = 4,
    parameter int unsigned VLEN    = 4096
);
    import masku_alu_seq_pkg::*;

    localparam int unsigned DW = masku_dw(NrLanes);
    localparam int unsigned VW = $clog2(VLEN) + 1;
    localparam int unsigned CW = idx_width(DW) + 1;

    logic               vinsn_valid_i;
    logic               vinsn_ready_o;
    logic [VW-1:0]      vl_i;
    vew_e               vsew_i;
    logic [NrLanes-1:0] operand_valid_i;
    logic [NrLanes-1:0] operand_ready_o;
    logic [DW-1:0]      compressed_i;
    logic [CW-1:0]      vrf_pnt_o;
    logic               result_valid_o;
    logic               result_ready_i;
    logic [DW-1:0]      result_data_o;
    logic [CW-1:0]      result_cnt_o;
    logic               result_last_o;
    logic               vinsn_done_o;

    modport master (
        output vinsn_valid_i, vl_i, vsew_i, operand_valid_i, compressed_i, result_ready_i,
        input  vinsn_ready_o, operand_ready_o, vrf_pnt_o, result_valid_o,
               result_data_o, result_cnt_o, result_last_o, vinsn_done_o
    );

    modport slave (
        input  vinsn_valid_i, vl_i, vsew_i, operand_valid_i, compressed_i, result_ready_i,
        output vinsn_ready_o, operand_ready_o, vrf_pnt_o, result_valid_o,
               result_data_o, result_cnt_o, result_last_o, vinsn_done_o
    );

endinterface

// File: rtl/masku_seq_outreg.sv
// Mask-word output register: valid/ready hold with same-cycle accept and reload.
module masku_seq_outreg #(
    parameter int unsigned DW = 256,
    parameter int unsigned CW = 9
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [DW-1:0] load_data,
    input  logic [CW-1:0] load_cnt,
    input  logic          load_last,
    input  logic          ready,
    output logic          valid,
    output logic [DW-1:0] data,
    output logic [CW-1:0] cnt,
    output logic          last
);

    // A reload wins over the clear so back-to-back words stream at one per cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= 1'b0;
            data  <= '0;
            cnt   <= '0;
            last  <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            data  <= load_data;
            cnt   <= load_cnt;
            last  <= load_last;
        end else if (ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/masku_alu_seq.sv
// Sequences compressed ALU/FPU comparison beats into datapath-wide mask words.
// Optional stall counters are enabled with MASKU_SEQ_PERF_EN.
module masku_alu_seq
    import masku_alu_seq_pkg::*;
#(
    parameter int unsigned NrLanes = 4,
    parameter int unsigned VLEN    = 4096
) (
    input  logic              clk_i,
    input  logic              rst_i,
    masku_alu_seq_if.slave    bus
`ifdef MASKU_SEQ_PERF_EN
    ,
    output logic [31:0]       stall_operand_cnt_o,
    output logic [31:0]       stall_wb_cnt_o
`endif
);

    localparam int unsigned DW = masku_dw(NrLanes);
    localparam int unsigned VW = $clog2(VLEN) + 1;
    localparam int unsigned CW = idx_width(DW) + 1;

    masku_seq_state_e state;
    vew_e             vsew_q;
    logic [VW-1:0]    rem_q;
    logic [CW-1:0]    pnt_q;
    logic [DW-1:0]    acc_q;

    logic [CW-1:0]    beat;
    logic [CW-1:0]    take;
    logic [CW-1:0]    out_cnt;
    logic [DW-1:0]    nxt;
    logic             all_valid;
    logic             free;
    logic             fire;
    logic             last_beat;
    logic             word_full;
    logic             load;
    logic             out_valid;
    logic             out_last;

    // Beat bookkeeping: a word leaves on the final beat or when the accumulator fills
    always_comb begin
        beat      = CW'(beat_elems(vsew_q, NrLanes));
        all_valid = &bus.operand_valid_i;
        free      = !out_valid || bus.result_ready_i;
        fire      = (state == RUN) && free && all_valid;
        last_beat = rem_q <= VW'(beat);
        word_full = (pnt_q + beat) == CW'(DW);
        take      = last_beat ? CW'(rem_q) : beat;
        out_cnt   = pnt_q + take;
        nxt       = acc_q | bus.compressed_i;
        load      = fire && (last_beat || word_full);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state  <= IDLE;
            vsew_q <= EW8;
            rem_q  <= '0;
            pnt_q  <= '0;
            acc_q  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.vinsn_valid_i) begin
                        vsew_q <= bus.vsew_i;
                        rem_q  <= bus.vl_i;
                        pnt_q  <= '0;
                        acc_q  <= '0;
                        state  <= (bus.vl_i != '0) ? RUN : DONE;
                    end
                end
                RUN: begin
                    if (fire) begin
                        rem_q <= rem_q - VW'(take);
                        if (load) begin
                            acc_q <= '0;
                            pnt_q <= '0;
                        end else begin
                            acc_q <= nxt;
                            pnt_q <= pnt_q + beat;
                        end
                        if (last_beat) state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (out_valid && bus.result_ready_i && out_last) state <= DONE;
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    masku_seq_outreg #(
        .DW (DW),
        .CW (CW)
    ) u_outreg (
        .clk       (clk_i),
        .rst       (rst_i),
        .load      (load),
        .load_data (nxt),
        .load_cnt  (out_cnt),
        .load_last (last_beat),
        .ready     (bus.result_ready_i),
        .valid     (out_valid),
        .data      (bus.result_data_o),
        .cnt       (bus.result_cnt_o),
        .last      (out_last)
    );

    assign bus.vinsn_ready_o   = (state == IDLE);
    assign bus.vinsn_done_o    = (state == DONE);
    assign bus.operand_ready_o = {NrLanes{fire}};
    assign bus.vrf_pnt_o       = pnt_q;
    assign bus.result_valid_o  = out_valid;
    assign bus.result_last_o   = out_last;

`ifdef MASKU_SEQ_PERF_EN
    logic [31:0] stall_op_q;
    logic [31:0] stall_wb_q;

    // Saturating stall counters, restarted for every accepted instruction
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stall_op_q <= '0;
            stall_wb_q <= '0;
        end else if (state == IDLE && bus.vinsn_valid_i) begin
            stall_op_q <= '0;
            stall_wb_q <= '0;
        end else if (state == RUN) begin
            if (free && !all_valid && stall_op_q != '1) stall_op_q <= stall_op_q + 32'd1;
            if (!free && stall_wb_q != '1)              stall_wb_q <= stall_wb_q + 32'd1;
        end
    end

    assign stall_operand_cnt_o = stall_op_q;
    assign stall_wb_cnt_o      = stall_wb_q;
`endif

endmodule
